// File: rtl/bios_fetch.sv
// BIOS instruction fetch: owns the PC, drives the 1-cycle sync-read memory, pairs words with PC/valid.
// Latency addr->inst 1 cycle; stall holds all state with imem_en low, redirect overrides stall.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BIOS_MEM_ADDR_WIDTH
`define BIOS_MEM_ADDR_WIDTH 12
`endif

module bios_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h4000_0000,
    parameter int          ADDR_WIDTH = `BIOS_MEM_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_redirect_valid,
    input  logic [`XLEN-1:0]      i_redirect_pc,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic                  o_imem_en,
    input  logic [`XLEN-1:0]      i_imem_dout,
    output logic [`XLEN-1:0]      o_inst,
    output logic [`XLEN-1:0]      o_inst_pc,
    output logic                  o_inst_valid,
    output logic                  o_misalign_err,
    output logic [31:0]           o_fetch_cnt
);

    localparam logic [`XLEN-1:0] NOP = 32'h0000_0013;

    logic [`XLEN-1:0] r_pc_f;
    logic             r_valid_f;
    logic             r_misalign_err;
    logic [31:0]      r_fetch_cnt;

    logic             w_advance;
    logic [`XLEN-1:0] w_next_pc;
    logic             w_inst_valid;
    logic             w_unused;

    assign w_advance    = ~i_stall | i_redirect_valid;
    assign w_next_pc    = i_redirect_valid ? {i_redirect_pc[`XLEN-1:2], 2'b00} : r_pc_f + 32'd4;
    assign w_inst_valid = r_valid_f & ~i_redirect_valid;

    // Upper PC bits are dropped on purpose so the fetch wraps inside the BIOS window.
    assign o_imem_addr    = w_next_pc[ADDR_WIDTH+1:2];
    assign o_imem_en      = w_advance & ~i_reset;
    assign o_inst_valid   = w_inst_valid;
    assign o_inst         = w_inst_valid ? i_imem_dout : NOP;
    assign o_inst_pc      = r_pc_f;
    assign o_misalign_err = r_misalign_err;
    assign o_fetch_cnt    = r_fetch_cnt;

    assign w_unused = &{1'b0, w_next_pc[`XLEN-1:ADDR_WIDTH+2], w_next_pc[1:0], 1'b0};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc_f         <= RESET_PC - 32'd4;
            r_valid_f      <= 1'b0;
            r_misalign_err <= 1'b0;
            r_fetch_cnt    <= 32'd0;
        end else begin
            if (w_advance) begin
                r_pc_f    <= w_next_pc;
                r_valid_f <= 1'b1;
            end
            if (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) begin
                r_misalign_err <= 1'b1;
            end
            if (w_inst_valid && !i_stall) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

endmodule
